sliding_window_3x3: RTL and testbench
=====================================

Name: sliding_window_3x3

Overview:
- Raster-to-window front end for `filter`. Accepts one 8-bit pixel per valid cycle in row-major order.
- Keeps two line buffers and a 3x3 register window, and presents the nine window pixels to `filter` on `sw_pixels1..9` with a one-cycle `win_valid` strobe.
- Produces windows only for interior centres, so one frame of W x H pixels yields (W-2)*(H-2) windows.

Parameters:
- IMG_W, 256, pixels per row; legal range 3..1024.
- IMG_H, 256, rows per frame; legal range 3..1024.

Ports:
- clk  in  1  system clock, all logic on rising edge.
- rst_n  in  1  asynchronous active-low reset.
- start  in  1  frame-start pulse; clears row/col counters.
- in_valid  in  1  `in_pixel` valid this cycle.
- in_pixel  in  8  input pixel, unsigned.
- win_valid  out  1  `sw_pixels1..9` hold a new interior window (1-cycle pulse).
- sw_pixels1 .. sw_pixels9  out  8 each  window, row-major; 1 = top-left, 5 = centre, 9 = bottom-right.
- frame_done  out  1  pulse coincident with the last window of a frame.
- busy  out  1  high from the first accepted pixel until the last pixel of the frame is accepted.

Behaviour:
- Reset (async on rst_n low):
  - col, row, win_valid, frame_done and busy go to 0.
  - sw_pixels1..9 go to 0.
  - Line buffer contents are not reset.
- Counters:
  - col runs 0..IMG_W-1 and increments on each accepted pixel (in_valid=1).
  - At IMG_W-1, col wraps to 0 and row increments.
  - At (IMG_H-1, IMG_W-1), both wrap to 0 and busy clears.
- Line buffers:
  - lb_top[IMG_W] holds row r-2; lb_mid[IMG_W] holds row r-1.
  - On an accepted pixel at (r,c): read t = lb_top[c] and m = lb_mid[c], then write lb_top[c] <= m and lb_mid[c] <= in_pixel.
  - Read-before-write within the same cycle is required.
- Window shift, on each accepted pixel:
  - Left column takes the old middle column; middle column takes the old right column.
  - New right column is (sw3, sw6, sw9) <= (t, m, in_pixel).
  - Result: the top row is image row r-2, the centre (sw5) is pixel (r-1, c-1), and sw9 is (r, c).
- Latency: window outputs and win_valid are registered one cycle after the accepting edge.
- win_valid: asserted for the accepted pixel iff row >= 2 and col >= 2. Windows formed at col 0/1 contain stale columns and are never flagged.
- frame_done: asserted with win_valid for pixel (IMG_H-1, IMG_W-1).
- Stall (in_valid=0):
  - Counters, buffers and window hold.
  - win_valid and frame_done are 0.
  - sw_pixels keep their last value.
- start:
  - start=1 forces col=row=0 and clears busy before any pixel in the same cycle is processed.
  - If in_valid=1 in that same cycle, the pixel is accepted as (0,0).
  - A start in mid-frame abandons the frame; no frame_done is issued for it, and rows 0/1 of the new frame refill the buffers.
- Back-to-back frames need no gap; stale buffer data from the previous frame is never flagged valid, because of the row >= 2 rule.
- Reset mid-frame behaves the same as a start plus clearing outputs.
- No backpressure: `filter` accepts every window.
- Output pixels are passed through unmodified; there is no arithmetic on pixel values.

Test Plan:
- Frame, IMG_W=IMG_H=4, pixel = 16*row + col, in_valid continuous -> first win_valid one cycle after pixel 0x22 is accepted, with sw1..9 = 00,01,02,10,11,12,20,21,22. Exactly 4 windows follow, with centres 11,12,21,22. frame_done rises only with centre 22.
- Same frame with in_valid toggling 1/0 each cycle -> identical 4 windows. win_valid never high on an in_valid=0 cycle, and outputs hold between windows.
- Two frames back-to-back, second frame = first + 0x80 -> 8 windows total. Second-frame windows contain only 0x80-based values; none is flagged during its rows 0-1.
- rst_n low for one cycle after 7 pixels, then a full frame -> all outputs 0 immediately on reset. The following frame produces exactly 4 correct windows.
- start asserted together with in_valid at pixel 9 of a frame -> that pixel is treated as (0,0). No frame_done for the aborted frame. The new frame's first window appears after its 11th pixel.
- IMG_W=5, IMG_H=3 ramp -> exactly 3 windows with centres (1,1),(1,2),(1,3). frame_done with the third. busy falls after pixel 14.

Source files
------------

// File: rtl/sliding_window_3x3.sv
// Raster-to-window front end: two line buffers plus a 3x3 register window fed one pixel per valid cycle.
// Latency: one cycle from the accepting edge to the window/win_valid; no backpressure, every window is taken.
module sliding_window_3x3 #(
  parameter int IMG_W = 256,
  parameter int IMG_H = 256
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       start,
  input  logic       in_valid,
  input  logic [7:0] in_pixel,
  output logic       win_valid,
  output logic [7:0] sw_pixels1,
  output logic [7:0] sw_pixels2,
  output logic [7:0] sw_pixels3,
  output logic [7:0] sw_pixels4,
  output logic [7:0] sw_pixels5,
  output logic [7:0] sw_pixels6,
  output logic [7:0] sw_pixels7,
  output logic [7:0] sw_pixels8,
  output logic [7:0] sw_pixels9,
  output logic       frame_done,
  output logic       busy
);

  localparam int CW = $clog2(IMG_W);
  localparam int RW = $clog2(IMG_H);

  logic [CW-1:0] col, col_e;
  logic [RW-1:0] row, row_e;
  logic          col_last, row_last;
  logic [7:0]    lb_top [IMG_W];
  logic [7:0]    lb_mid [IMG_W];
  logic [7:0]    t, m;

  // start overrides the stored position so a same-cycle pixel lands at (0,0)
  assign col_e    = start ? '0 : col;
  assign row_e    = start ? '0 : row;
  assign col_last = (col_e == CW'(IMG_W - 1));
  assign row_last = (row_e == RW'(IMG_H - 1));

  assign t = lb_top[col_e];
  assign m = lb_mid[col_e];

  always_ff @(posedge clk) begin
    if (in_valid) begin
      lb_top[col_e] <= m;
      lb_mid[col_e] <= in_pixel;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      col  <= '0;
      row  <= '0;
      busy <= 1'b0;
    end else if (in_valid) begin
      if (col_last) begin
        col <= '0;
        row <= row_last ? '0 : row_e + RW'(1);
      end else begin
        col <= col_e + CW'(1);
        row <= row_e;
      end
      busy <= !(col_last && row_last);
    end else if (start) begin
      col  <= '0;
      row  <= '0;
      busy <= 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      win_valid  <= 1'b0;
      frame_done <= 1'b0;
      sw_pixels1 <= '0;
      sw_pixels2 <= '0;
      sw_pixels3 <= '0;
      sw_pixels4 <= '0;
      sw_pixels5 <= '0;
      sw_pixels6 <= '0;
      sw_pixels7 <= '0;
      sw_pixels8 <= '0;
      sw_pixels9 <= '0;
    end else begin
      // stale columns at col 0/1 and stale rows 0/1 are shifted through but never flagged
      win_valid  <= in_valid && (row_e >= RW'(2)) && (col_e >= CW'(2));
      frame_done <= in_valid && row_last && col_last;
      if (in_valid) begin
        sw_pixels1 <= sw_pixels2;
        sw_pixels2 <= sw_pixels3;
        sw_pixels3 <= t;
        sw_pixels4 <= sw_pixels5;
        sw_pixels5 <= sw_pixels6;
        sw_pixels6 <= m;
        sw_pixels7 <= sw_pixels8;
        sw_pixels8 <= sw_pixels9;
        sw_pixels9 <= in_pixel;
      end
    end
  end

endmodule

// File: tb/tb_sliding_window_3x3.sv
// Directed bench: 4x4 instance for framing, stall, back-to-back, reset and start cases; 5x3 instance for a non-square frame.
module tb_sliding_window_3x3;

  localparam int W = 4;
  localparam int H = 4;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       start, in_valid;
  logic [7:0] in_pixel;
  logic       win_valid, frame_done, busy;
  logic [7:0] s1, s2, s3, s4, s5, s6, s7, s8, s9;
  logic       start_b, in_valid_b;
  logic [7:0] in_pixel_b;
  logic       wv_b, fd_b, busy_b;
  logic [7:0] b1, b2, b3, b4, b5, b6, b7, b8, b9;
  logic [71:0] win_a, win_b;

  always #5 clk = ~clk;

  sliding_window_3x3 #(.IMG_W(W), .IMG_H(H)) u_dut (
    .clk(clk), .rst_n(rst_n), .start(start), .in_valid(in_valid), .in_pixel(in_pixel),
    .win_valid(win_valid),
    .sw_pixels1(s1), .sw_pixels2(s2), .sw_pixels3(s3), .sw_pixels4(s4), .sw_pixels5(s5),
    .sw_pixels6(s6), .sw_pixels7(s7), .sw_pixels8(s8), .sw_pixels9(s9),
    .frame_done(frame_done), .busy(busy)
  );

  sliding_window_3x3 #(.IMG_W(5), .IMG_H(3)) u_dut_b (
    .clk(clk), .rst_n(rst_n), .start(start_b), .in_valid(in_valid_b), .in_pixel(in_pixel_b),
    .win_valid(wv_b),
    .sw_pixels1(b1), .sw_pixels2(b2), .sw_pixels3(b3), .sw_pixels4(b4), .sw_pixels5(b5),
    .sw_pixels6(b6), .sw_pixels7(b7), .sw_pixels8(b8), .sw_pixels9(b9),
    .frame_done(fd_b), .busy(busy_b)
  );

  assign win_a = {s1, s2, s3, s4, s5, s6, s7, s8, s9};
  assign win_b = {b1, b2, b3, b4, b5, b6, b7, b8, b9};

  int n_chk = 0;
  int n_fail = 0;

  task automatic check(input string tag, input logic [71:0] obs, input logic [71:0] exp);
    n_chk++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Window monitor for the 4x4 instance; mon_acc is the in_valid seen at the edge that produced the sample
  logic [71:0] win_log [64];
  logic        fd_log  [64];
  int          n_win = 0, n_fd = 0, bad_vld = 0, bad_hold = 0, fd_alone = 0;
  logic [71:0] last_out = '0;
  logic        mon_acc;

  always @(posedge clk) begin
    mon_acc = in_valid;
    #1;
    if (win_valid) begin
      if (n_win < 64) begin
        win_log[n_win] = win_a;
        fd_log[n_win]  = frame_done;
      end
      n_win++;
      if (!mon_acc) bad_vld++;
    end else if (frame_done) begin
      fd_alone++;
    end
    if (frame_done) n_fd++;
    if (!mon_acc && win_a !== last_out) bad_hold++;
    last_out = win_a;
  end

  function automatic logic [71:0] exp_win(input logic [7:0] base, input int r, input int c);
    logic [71:0] v = '0;
    for (int dr = 0; dr < 3; dr++)
      for (int dc = 0; dc < 3; dc++)
        v = {v[63:0], 8'(int'(base) + 16 * (r - 2 + dr) + (c - 2 + dc))};
    return v;
  endfunction

  task automatic px(input logic [7:0] p, input logic st);
    @(negedge clk);
    in_valid = 1'b1;
    start    = st;
    in_pixel = p;
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      in_valid = 1'b0;
      start    = 1'b0;
      @(posedge clk);
      #1;
    end
  endtask

  task automatic send_frame(input logic [7:0] base, input bit toggle, input bit chk);
    for (int r = 0; r < H; r++)
      for (int c = 0; c < W; c++) begin
        px(8'(int'(base) + 16 * r + c), 1'b0);
        if (chk) begin
          check("vld_timing", win_valid, (r >= 2 && c >= 2));
          check("busy", busy, !(r == H - 1 && c == W - 1));
        end
        if (toggle) idle(1);
      end
  endtask

  task automatic check_frame(input string tag, input int first, input logic [7:0] base);
    int k = first;
    for (int r = 2; r < H; r++)
      for (int c = 2; c < W; c++) begin
        check({tag, "_win"}, win_log[k], exp_win(base, r, c));
        check({tag, "_fd"}, fd_log[k], (r == H - 1 && c == W - 1));
        k++;
      end
  endtask

  initial begin
    int n0, v0, h0, f0, a0;
    rst_n = 1'b0;
    start = 1'b0; in_valid = 1'b0; in_pixel = '0;
    start_b = 1'b0; in_valid_b = 1'b0; in_pixel_b = '0;
    #2;
    check("rst_win", win_a, '0);
    check("rst_busy", busy, 1'b0);
    check("rst_vld", win_valid, 1'b0);
    check("rst_fd", frame_done, 1'b0);
    @(negedge clk);
    rst_n = 1'b1;

    // continuous frame
    n0 = n_win; a0 = fd_alone;
    send_frame(8'h00, 1'b0, 1'b1);
    idle(2);
    check("t1_count", n_win - n0, 4);
    check_frame("t1", n0, 8'h00);
    check("t1_fd_alone", fd_alone - a0, 0);

    // in_valid toggling
    n0 = n_win; v0 = bad_vld; h0 = bad_hold;
    send_frame(8'h00, 1'b1, 1'b1);
    idle(2);
    check("t2_count", n_win - n0, 4);
    check_frame("t2", n0, 8'h00);
    check("t2_vld_on_stall", bad_vld - v0, 0);
    check("t2_hold", bad_hold - h0, 0);

    // back-to-back frames
    n0 = n_win;
    send_frame(8'h00, 1'b0, 1'b0);
    send_frame(8'h80, 1'b0, 1'b0);
    idle(2);
    check("t3_count", n_win - n0, 8);
    check_frame("t3a", n0, 8'h00);
    check_frame("t3b", n0 + 4, 8'h80);

    // reset mid-frame
    n0 = n_win;
    for (int i = 0; i < 7; i++) px(8'(16 * (i / W) + i % W), 1'b0);
    check("t4_busy_pre", busy, 1'b1);
    @(negedge clk);
    in_valid = 1'b0;
    rst_n = 1'b0;
    #1;
    check("t4_rst_win", win_a, '0);
    check("t4_rst_busy", busy, 1'b0);
    check("t4_rst_vld", win_valid, 1'b0);
    check("t4_rst_fd", frame_done, 1'b0);
    @(negedge clk);
    rst_n = 1'b1;
    check("t4_no_early_win", n_win - n0, 0);
    n0 = n_win;
    send_frame(8'h00, 1'b0, 1'b1);
    idle(2);
    check("t4_count", n_win - n0, 4);
    check_frame("t4", n0, 8'h00);

    // start mid-frame at the tenth pixel
    n0 = n_win; f0 = n_fd;
    for (int i = 0; i < 9; i++) px(8'(16 * (i / W) + i % W), 1'b0);
    for (int k = 0; k < W * H; k++) begin
      px(8'(8'h40 + 16 * (k / W) + k % W), k == 0);
      check("t5_vld", win_valid, (k / W >= 2 && k % W >= 2));
      if (k == 0) check("t5_busy", busy, 1'b1);
    end
    idle(2);
    check("t5_count", n_win - n0, 4);
    check_frame("t5", n0, 8'h40);
    check("t5_fd_count", n_fd - f0, 1);

    // 5x3 frame on the second instance
    for (int i = 0; i < 15; i++) begin
      @(negedge clk);
      in_valid_b = 1'b1;
      in_pixel_b = 8'(16 * (i / 5) + i % 5);
      @(posedge clk);
      #1;
      check("b_vld", wv_b, (i / 5 >= 2 && i % 5 >= 2));
      check("b_fd", fd_b, (i == 14));
      check("b_busy", busy_b, (i != 14));
      if (i >= 12) begin
        check("b_centre", b5, 8'(8'h10 + i % 5 - 1));
        check("b_win", win_b, exp_win(8'h00, 2, i % 5));
      end
    end
    @(negedge clk);
    in_valid_b = 1'b0;
    @(posedge clk);
    #1;
    check("b_vld_after", wv_b, 1'b0);
    check("b_busy_after", busy_b, 1'b0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
